fifo_rr_write_arbiter: RTL and testbench

//  Shares the single write port of one FIFO among NUM_REQ producers, using round-robin bursts.

---
 rtl/fifo_rr_write_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_fifo_rr_write_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin burst arbiter for the write port of a single FIFO.
// Up to NUM_REQ producers compete for the port. A winner keeps the port for up to
// BURST_LEN accepted words, or until it drops valid. One IDLE bubble always separates
// two grants. The FIFO full flag is used combinationally to stall the current owner.
//
// Handshake: requester i offers a word by raising req_valid[i] with the word on its
// req_data slice. The word is consumed on a rising clock edge where
// req_valid[i] & req_ready[i] is 1. After raising valid, the requester holds valid and
// data stable until that edge. Lowering valid while it owns the port ends the grant
// and gives up the rest of the burst.
module fifo_rr_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 10,
  parameter int BURST_LEN = 4,
  parameter int ID_BITS   = 2,
  parameter int CNT_BITS  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_write,
  output logic [DATA_BITS-1:0]         fifo_input_data,
  output logic [ID_BITS-1:0]           grant_id,
  output logic                         busy,
  output logic                         state_dbg
);

  // Elaboration-time sanity checks on the parameter set.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("fifo_rr_write_arbiter: NUM_REQ must be in 2..16");
  end
  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("fifo_rr_write_arbiter: BURST_LEN must be at least 1");
  end
  if ((1 << ID_BITS) < NUM_REQ) begin : g_bad_id_bits
    $error("fifo_rr_write_arbiter: ID_BITS too narrow for NUM_REQ");
  end
  if ((1 << CNT_BITS) <= BURST_LEN) begin : g_bad_cnt_bits
    $error("fifo_rr_write_arbiter: CNT_BITS too narrow for BURST_LEN");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Registered state
  state_t              state;
  logic [ID_BITS-1:0]  last_grant;
  logic [CNT_BITS-1:0] burst_cnt;

  // Next-state values
  state_t              state_nxt;
  logic [ID_BITS-1:0]  grant_nxt;
  logic [ID_BITS-1:0]  last_nxt;
  logic [CNT_BITS-1:0] cnt_nxt;

  // Arbitration results
  logic                hi_found;
  logic                lo_found;
  logic [ID_BITS-1:0]  hi_id;
  logic [ID_BITS-1:0]  lo_id;
  logic                any_valid;
  logic [ID_BITS-1:0]  winner;

  // Owner view
  logic                 owner_valid;
  logic [DATA_BITS-1:0] owner_data;
  logic                 port_open;
  logic                 transfer;
  logic                 burst_last;

  assign busy      = (state == GRANT);
  assign state_dbg = state;

  // The port can take a word only in GRANT, outside reset, with room in the FIFO.
  assign port_open  = busy & ~reset & ~fifo_full;
  assign transfer   = port_open & owner_valid;
  assign fifo_write = transfer;
  assign burst_last = (burst_cnt == CNT_BITS'(BURST_LEN - 1));

  // Round-robin search: the lowest-numbered valid requester above last_grant wins;
  // if there is none, the lowest-numbered valid requester at or below it wins.
  // This equals a search upward from last_grant+1 that wraps modulo NUM_REQ.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (ID_BITS'(i) > last_grant) begin
          hi_found = 1'b1;
          hi_id    = ID_BITS'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = ID_BITS'(i);
        end
      end
    end
    any_valid = hi_found | lo_found;
    winner    = hi_found ? hi_id : lo_id;
  end

  // Select the current owner's valid bit and data slice.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_BITS'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // The FIFO data bus follows the owner's slice while busy and is held at zero otherwise.
  always_comb begin
    fifo_input_data = '0;
    if (busy) begin
      fifo_input_data = owner_data;
    end
  end

  // Only the owner sees ready, and only while the port is open.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = port_open & (grant_id == ID_BITS'(i));
    end
  end

  // Next-state logic: arbitrate in IDLE, then count, stall or release in GRANT.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_grant;
    cnt_nxt   = burst_cnt;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_nxt = winner;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!owner_valid) begin
          // Owner withdrew: release without a write, whatever the full flag says.
          state_nxt = IDLE;
          last_nxt  = grant_id;
          cnt_nxt   = '0;
        end else if (!fifo_full) begin
          if (burst_last) begin
            state_nxt = IDLE;
            last_nxt  = grant_id;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = burst_cnt + CNT_BITS'(1);
          end
        end
        // Owner valid with the FIFO full: stall and keep everything unchanged.
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers; reset leaves last_grant on the top index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_BITS'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
      burst_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Self-checking bench for fifo_rr_write_arbiter: directed scenarios plus a randomized run
// with a queue-based FIFO attached, all compared against a cycle-level reference model.
module tb_fifo_rr_write_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_BITS = 10;
  localparam int BURST_LEN = 4;
  localparam int ID_BITS   = 2;
  localparam int CNT_BITS  = 3;
  localparam int W         = 32;
  localparam int DEPTH     = 6;
  localparam int MAXW      = 64;
  localparam int RAND_N    = 40;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         reset;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         fifo_full;
  logic                         fifo_write;
  logic [DATA_BITS-1:0]         fifo_input_data;
  logic [ID_BITS-1:0]           grant_id;
  logic                         busy;
  logic                         state_dbg;

  fifo_rr_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS), .BURST_LEN(BURST_LEN),
    .ID_BITS(ID_BITS), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write(fifo_write),
    .fifo_input_data(fifo_input_data), .grant_id(grant_id), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  logic [W-1:0]         exp_q[$];   // expected writes: {cycle, data}
  logic [DATA_BITS-1:0] wlog[$];    // observed write data
  int                   wcyc[$];    // observed write cycles
  logic [ID_BITS-1:0]   glog[$];    // observed grant starts

  // Producer sources
  logic [DATA_BITS-1:0] src [NUM_REQ][MAXW];
  int src_n [NUM_REQ];
  int src_i [NUM_REQ];
  bit rnd_valid = 1'b0;

  // FIFO model
  bit use_fifo   = 1'b0;
  bit full_force = 1'b0;
  int drain_pct  = 50;
  logic [DATA_BITS-1:0] fifo_q[$];
  int next_seq [NUM_REQ];
  int popped   [NUM_REQ];

  // Values captured at the falling edge for the driver
  bit                   wr_s  = 1'b0;
  logic [DATA_BITS-1:0] wd_s  = '0;
  bit [NUM_REQ-1:0]     acc_s = '0;
  bit                   prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_BITS-1:0] tag(input int id, input int seq);
    logic [1:0] idb;
    logic [7:0] sb;
    idb = id[1:0];
    sb  = seq[7:0];
    return {idb, sb};
  endfunction

  // ---------------- reference model ----------------
  // Owner is -1 when no grant is held; taken counts words accepted in the current grant.
  int m_owner = -1;
  int m_taken = 0;
  int m_last  = NUM_REQ - 1;

  always @(negedge clk) begin : model
    logic [NUM_REQ-1:0]   exp_ready;
    logic [DATA_BITS-1:0] exp_data;
    bit                   exp_busy;
    int                   c;
    exp_busy  = (m_owner >= 0);
    exp_ready = '0;
    exp_data  = '0;
    if (exp_busy) exp_data = req_data[m_owner*DATA_BITS +: DATA_BITS];
    if (!reset && exp_busy && !fifo_full) exp_ready[m_owner] = 1'b1;
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("state_dbg", state_dbg, exp_busy);
      check("req_ready", req_ready, exp_ready);
      check("fifo_input_data", fifo_input_data, exp_data);
      if (exp_busy) check("grant_id", grant_id, m_owner);
    end
    if (reset) begin
      m_owner = -1;
      m_taken = 0;
      m_last  = NUM_REQ - 1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (m_last + k) % NUM_REQ;
        if (req_valid[c]) begin
          m_owner = c;
          m_taken = 0;
          break;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (!fifo_full) begin
      if (chk_en) exp_q.push_back({cyc[21:0], req_data[m_owner*DATA_BITS +: DATA_BITS]});
      m_taken++;
      if (m_taken == BURST_LEN) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    #1;
    if (chk_en) begin
      if (fifo_full === 1'b1) check("no_write_while_full", fifo_write, 1'b0);
      if (reset === 1'b1) check("no_write_in_reset", fifo_write, 1'b0);
      if (fifo_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got 0x%0h expected no write (cycle %0d)",
                   fifo_input_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("write", {cyc[21:0], fifo_input_data}, e);
        end
        wlog.push_back(fifo_input_data);
        wcyc.push_back(cyc);
      end
      if (busy === 1'b1 && !prev_busy) glog.push_back(grant_id);
    end
    prev_busy = (busy === 1'b1);
    wr_s  = (fifo_write === 1'b1);
    wd_s  = fifo_input_data;
    acc_s = req_valid & req_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [DATA_BITS-1:0] d;
    int id;
    @(posedge clk);
    #1;
    if (use_fifo) begin
      if (wr_s) fifo_q.push_back(wd_s);
      if (fifo_q.size() > 0 && $urandom_range(0, 99) < drain_pct) begin
        d  = fifo_q.pop_front();
        id = int'(d[9:8]);
        check("fifo_order", d[7:0], next_seq[id]);
        next_seq[id]++;
        popped[id]++;
      end
      fifo_full = (fifo_q.size() == DEPTH);
    end else begin
      fifo_full = full_force;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_s[i]) src_i[i]++;
      if (!(req_valid[i] && !acc_s[i])) begin
        if (src_i[i] < src_n[i] && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
          req_valid[i] = 1'b1;
          req_data[i*DATA_BITS +: DATA_BITS] = src[i][src_i[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic clear_logs();
    wlog.delete();
    wcyc.delete();
    glog.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_n[i] = 0;
      src_i[i] = 0;
    end
    req_valid  = '0;
    full_force = 1'b0;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic load(input int id, input int n, input int base);
    src_n[id] = n;
    src_i[id] = 0;
    for (int k = 0; k < n; k++) src[id][k] = (base < 0) ? tag(id, k) : DATA_BITS'(base + k);
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    while (wlog.size() < n && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (wlog.size() < n) begin
      failures++;
      $display("FAIL %s_timeout: got %0d writes expected %0d", name, wlog.size(), n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int t0;
    int total;
    int budget;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_n[i] = 0;
      src_i[i] = 0;
    end
    step();
    step();
    chk_en = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 0);
    check("rst_state", state_dbg, 1'b0);
    check("rst_ready", req_ready, 0);
    check("rst_write", fifo_write, 1'b0);
    reset = 1'b0;
    clear_logs();

    // 1: lone requester 1 with six words
    load(1, 6, 'h10);
    step();
    t0 = cyc;
    wait_writes(6, 40, "t1");
    for (int k = 0; k < 6; k++) check("t1_data", wlog[k], 'h10 + k);
    check("t1_cyc0", wcyc[0] - t0, 1);
    check("t1_cyc3", wcyc[3] - t0, 4);
    check("t1_cyc4", wcyc[4] - t0, 6);
    check("t1_cyc5", wcyc[5] - t0, 7);
    check("t1_grants", glog.size(), 2);
    check("t1_grant0", glog[0], 1);
    check("t1_grant1", glog[1], 1);
    repeat (3) step();

    // 2: all four continuously valid
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) load(i, 8, -1);
    wait_writes(32, 200, "t2");
    for (int k = 0; k < 5; k++) check("t2_order", glog[k], k % NUM_REQ);
    for (int k = 0; k < 16; k++) check("t2_data", wlog[k], tag(k / 4, k % 4));
    check("t2_gap", wcyc[4] - wcyc[3], 2);
    check("t2_run", wcyc[3] - wcyc[0], 3);
    repeat (3) step();

    // 3: FIFO full for three cycles after the second write of requester 0
    do_reset();
    load(0, 6, -1);
    wait_writes(2, 40, "t3a");
    full_force = 1'b1;
    fifo_full  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_stall_write", fifo_write, 1'b0);
      check("t3_stall_ready", req_ready[0], 1'b0);
      if (k == 2) full_force = 1'b0;
      step();
    end
    wait_writes(6, 40, "t3b");
    check("t3_stall_gap", wcyc[2] - wcyc[1], 4);
    check("t3_burst_end", wcyc[4] - wcyc[3], 2);
    check("t3_grants", glog.size(), 2);
    repeat (3) step();

    // 4: requester 2 drops after two words, requester 3 waiting
    do_reset();
    load(2, 2, -1);
    load(3, 4, -1);
    wait_writes(6, 40, "t4");
    check("t4_grant0", glog[0], 2);
    check("t4_grant1", glog[1], 3);
    check("t4_handover", wcyc[2] - wcyc[1], 3);
    check("t4_data", wlog[2], tag(3, 0));
    repeat (3) step();

    // 5: reset in the middle of requester 1's burst
    do_reset();
    load(1, 8, -1);
    wait_writes(2, 40, "t5a");
    reset = 1'b1;
    load(0, 4, -1);
    load(2, 4, -1);
    load(3, 4, -1);
    #1;
    check("t5_rst_write_a", fifo_write, 1'b0);
    step();
    #1;
    check("t5_rst_write_b", fifo_write, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    step();
    reset = 1'b0;
    clear_logs();
    wait_writes(1, 40, "t5b");
    check("t5_first_grant", glog[0], 0);
    check("t5_first_data", wlog[0], tag(0, 0));
    repeat (20) step();

    // 6: random valid gaps with a real FIFO draining at random rates
    do_reset();
    use_fifo  = 1'b1;
    rnd_valid = 1'b1;
    fifo_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      next_seq[i] = 0;
      popped[i]   = 0;
      load(i, RAND_N, -1);
    end
    total  = 0;
    budget = 20000;
    while (total < NUM_REQ * RAND_N && budget > 0) begin
      if (budget % 100 == 0) drain_pct = $urandom_range(15, 90);
      step();
      budget--;
      total = 0;
      for (int i = 0; i < NUM_REQ; i++) total += popped[i];
    end
    checks++;
    if (total < NUM_REQ * RAND_N) begin
      failures++;
      $display("FAIL t6_timeout: got %0d words expected %0d", total, NUM_REQ * RAND_N);
    end
    for (int i = 0; i < NUM_REQ; i++) check("t6_count", popped[i], RAND_N);
    repeat (3) step();
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound on run time.
  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
